// File: rtl/spu_pipe_pkg.sv
// Shared types and default field widths for the SPU inter-stage pipeline registers.
package spu_pipe_pkg;
  localparam int CTRL_W_DEF = 7;
  localparam int ALU_W_DEF  = 4;
  localparam int DEST_W_DEF = 7;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
  } stage_ctrl_t;

  // Encoding is {main_v, skid_v}, so bit 1 doubles as out_valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;
endpackage

// File: rtl/spu_pipe_slot.sv
// One payload register of the pipeline stage: load enable, async clear to zero.
module spu_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/spu_pipe_stage.sv
// Ready/valid pipeline register with 2-entry skid buffer, flush, bubble-safe control
// outputs and a saturating stall counter.
module spu_pipe_stage
  import spu_pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int ALU_W    = ALU_W_DEF,
  parameter int DATA_W   = 128,
  parameter int NUM_OPS  = 4,
  parameter int PC_W     = 11,
  parameter int DEST_W   = DEST_W_DEF,
  parameter int NUM_DEST = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [ALU_W-1:0]           in_alu,
  input  logic [NUM_OPS*DATA_W-1:0]  in_ops,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [NUM_DEST*DEST_W-1:0] in_dest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [ALU_W-1:0]           out_alu,
  output logic [NUM_OPS*DATA_W-1:0]  out_ops,
  output logic [PC_W-1:0]            out_pc,
  output logic [NUM_DEST*DEST_W-1:0] out_dest,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam int DST_W = NUM_DEST * DEST_W;
  localparam int PW    = CTRL_W + ALU_W + OPS_W + PC_W + DST_W;

  occ_e            occ, occ_nxt;
  logic            accept, consume;
  logic            main_ld, skid_ld, main_from_skid;
  logic [PW-1:0]   in_pl, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [ALU_W-1:0]  main_alu;

  assign in_pl     = {in_ctrl, in_alu, in_ops, in_pc, in_dest};
  assign out_valid = occ[1];
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    occ_nxt        = occ;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (occ)
      OCC_EMPTY: if (accept) begin
        occ_nxt = OCC_ONE;
        main_ld = 1'b1;
      end
      OCC_ONE: begin
        if (accept && consume) main_ld = 1'b1;
        else if (accept) begin
          occ_nxt = OCC_FULL;
          skid_ld = 1'b1;
        end else if (consume) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL: if (consume) begin
        occ_nxt        = OCC_ONE;
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
    // Flush wins over everything, including an accept in the same cycle.
    if (flush) begin
      occ_nxt = OCC_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= OCC_EMPTY;
      in_ready <= 1'b1;
    end else begin
      occ      <= occ_nxt;
      in_ready <= (occ_nxt != OCC_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  spu_pipe_slot #(.W(PW)) u_main (
    .clk(clk), .rst(reset), .ld(main_ld), .d(main_d), .q(main_q)
  );

  spu_pipe_slot #(.W(PW)) u_skid (
    .clk(clk), .rst(reset), .ld(skid_ld), .d(in_pl), .q(skid_q)
  );

  assign {main_ctrl, main_alu, out_ops, out_pc, out_dest} = main_q;
  // Bubbles must never carry live write-enables downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_alu  = out_valid ? main_alu  : '0;
endmodule

// File: tb/tb_spu_pipe_stage.sv
// Bench for spu_pipe_stage: directed scenarios plus random traffic against a queue model.
module tb_spu_pipe_stage;
  localparam int CTRL_W = 7, ALU_W = 4, DATA_W = 32, NUM_OPS = 3;
  localparam int PC_W = 11, DEST_W = 7, NUM_DEST = 2, CNT_W = 4;
  localparam int SAT = 15;

  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0]          in_ctrl, out_ctrl;
  logic [ALU_W-1:0]           in_alu, out_alu;
  logic [NUM_OPS*DATA_W-1:0]  in_ops, out_ops;
  logic [PC_W-1:0]            in_pc, out_pc;
  logic [NUM_DEST*DEST_W-1:0] in_dest, out_dest;
  logic [CNT_W-1:0]           stall_cnt;

  typedef struct packed {
    logic [CTRL_W-1:0]          ctrl;
    logic [ALU_W-1:0]           alu;
    logic [NUM_OPS*DATA_W-1:0]  ops;
    logic [PC_W-1:0]            pc;
    logic [NUM_DEST*DEST_W-1:0] dest;
  } entry_t;

  entry_t mq[$];
  bit     m_rdy;
  int     m_cnt;
  int     n_tests, n_fail;

  spu_pipe_stage #(
    .CTRL_W(CTRL_W), .ALU_W(ALU_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS),
    .PC_W(PC_W), .DEST_W(DEST_W), .NUM_DEST(NUM_DEST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_ops(in_ops), .in_pc(in_pc), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_ops(out_ops), .out_pc(out_pc),
    .out_dest(out_dest), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b1;
    m_cnt = 0;
  endtask

  task automatic check_all();
    entry_t f;
    bit v;
    v = (mq.size() > 0);
    f = v ? mq[0] : '0;
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, m_rdy);
    chk("out_ctrl", out_ctrl, f.ctrl);
    chk("out_alu", out_alu, f.alu);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (v) begin
      chk("out_ops", out_ops, f.ops);
      chk("out_pc", out_pc, f.pc);
      chk("out_dest", out_dest, f.dest);
    end
  endtask

  // One clock: model follows the FIFO rules of the stage, then outputs are compared.
  task automatic step();
    bit acc, con;
    entry_t cur;
    @(posedge clk);
    cur = '{ctrl: in_ctrl, alu: in_alu, ops: in_ops, pc: in_pc, dest: in_dest};
    acc = in_valid && m_rdy;
    con = (mq.size() > 0) && out_ready;
    if (mq.size() > 0 && !out_ready && m_cnt < SAT) m_cnt++;
    if (flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
      m_rdy = (mq.size() < 2);
    end
    #1 check_all();
  endtask

  task automatic rand_payload();
    in_ctrl = CTRL_W'($urandom);
    in_alu  = ALU_W'($urandom);
    in_ops  = {$urandom, $urandom, $urandom};
    in_pc   = PC_W'($urandom);
    in_dest = (NUM_DEST*DEST_W)'($urandom);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_alu = '0; in_ops = '0; in_pc = '0; in_dest = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_out_pc", out_pc, '0);
    chk("rst_stall", stall_cnt, '0);
    @(negedge clk) reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; rand_payload(); in_pc = PC_W'(i);
      step();
      chk("stream_pc", out_pc, PC_W'(i));
    end
    in_valid = 1'b0;
    step();

    // Back-pressure: A then B land in main and skid
    out_ready = 1'b0;
    in_valid = 1'b1; rand_payload(); in_pc = 11'h0A; step();
    rand_payload(); in_pc = 11'h0B; step();
    chk("bp_ready_low", in_ready, 1'b0);
    in_valid = 1'b0; step();
    out_ready = 1'b1;
    step();
    chk("bp_b_second", out_pc, 11'h0B);
    step();
    chk("bp_ready_back", in_ready, 1'b1);

    // Flush from FULL with C presented
    out_ready = 1'b0;
    in_valid = 1'b1; rand_payload(); step();
    rand_payload(); step();
    flush = 1'b1; rand_payload(); in_pc = 11'h0C; step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, '0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Async reset mid-stream while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; rand_payload(); step();
    rand_payload(); step();
    in_valid = 1'b0; repeat (2) step();
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ctrl", out_ctrl, '0);
    chk("mid_rst_stall", stall_cnt, '0);
    @(negedge clk) reset = 1'b0;
    #1 chk("mid_rst_ready", in_ready, 1'b1);

    // Stall counter saturation, survives flush
    in_valid = 1'b1; rand_payload(); step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("cnt_sat", stall_cnt, 4'd15);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("cnt_after_flush", stall_cnt, 4'd15);

    // Lane 2 carried bit-for-bit
    out_ready = 1'b1;
    in_valid = 1'b1; rand_payload(); in_ops[95:64] = 32'hDEADBEEF; step();
    chk("lane2", out_ops[95:64], 32'hDEADBEEF);
    in_valid = 1'b0; step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rand_payload();
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
